// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : word_assembler
//  Description : Debounces per-frame glove letter classifications into
//                committed characters, packs them into the Dictionary word
//                format (MAX_LEN slots of CHAR_W bits, slot 0 in the LSBs)
//                and hands the finished word to Dictionary with a start pulse,
//                holding it stable until Dictionary signals finish.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_assembler #(
  parameter int MAX_LEN    = 15,
  parameter int CHAR_W     = 8,
  parameter int STABLE_CNT = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  input  logic [7:0]                i_code,
  input  logic                      i_dict_finish,
  output logic                      o_start,
  output logic [MAX_LEN*CHAR_W-1:0] o_word,
  output logic [3:0]                o_len,
  output logic                      o_busy,
  output logic                      o_overflow
);

  // Run-length counter only needs to reach STABLE_CNT, where it saturates.
  localparam int               CNT_W     = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ARM   = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(STABLE_CNT);
  localparam logic [3:0]       LEN_ONE   = 4'd1;
  localparam logic [3:0]       LEN_FULL  = 4'(MAX_LEN);

  // Classifier code map.
  localparam logic [7:0] CODE_REST        = 8'd0;
  localparam logic [7:0] CODE_LAST_LETTER = 8'd26;
  localparam logic [7:0] CODE_BKSP        = 8'd27;
  localparam logic [7:0] CODE_END         = 8'd28;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  // Stability filter: current candidate code and how many consecutive
  // valid samples of it have been seen.
  logic [7:0]       cand;
  logic [CNT_W-1:0] cnt;

  // Word bookkeeping.
  logic [3:0]       len;
  logic             overflow;

  // Decoded per-cycle events.
  logic             code_ok;
  logic             run_same;
  logic             commit;
  logic             commit_letter;
  logic             commit_bksp;
  logic             commit_end;
  logic             do_write;
  logic             do_erase;
  logic             finish_now;

  // Next-state logic and commit decode; commits only exist while collecting.
  always_comb begin
    state_next    = state;
    code_ok       = (i_code <= CODE_END);
    run_same      = code_ok && (i_code == cand);
    commit        = 1'b0;
    commit_letter = 1'b0;
    commit_bksp   = 1'b0;
    commit_end    = 1'b0;
    finish_now    = 1'b0;
    case (state)
      S_COLLECT: begin
        // The commit edge is the one that moves the count from
        // STABLE_CNT-1 to STABLE_CNT; a saturated run never recommits.
        commit        = i_valid && run_same && (cnt == CNT_ARM);
        commit_letter = commit && (i_code != CODE_REST) && (i_code <= CODE_LAST_LETTER);
        commit_bksp   = commit && (i_code == CODE_BKSP);
        commit_end    = commit && (i_code == CODE_END);
        if (commit_end && (len != 4'd0)) begin
          state_next = S_START;
        end
      end
      S_START: begin
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_dict_finish) begin
          finish_now = 1'b1;
          state_next = S_COLLECT;
        end
      end
      default: begin
        state_next = S_COLLECT;
      end
    endcase
    do_write = commit_letter && (len != LEN_FULL);
    do_erase = commit_bksp && (len != 4'd0);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Stability filter; held cleared whenever a word is out with Dictionary.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || (state != S_COLLECT)) begin
      cand <= 8'd0;
      cnt  <= '0;
    end else if (i_valid) begin
      if (!code_ok) begin
        // Garbage sample breaks the run but keeps the candidate.
        cnt <= '0;
      end else if (run_same) begin
        if (cnt != CNT_FULL) begin
          cnt <= cnt + CNT_ONE;
        end
      end else begin
        cand <= i_code;
        cnt  <= CNT_ONE;
      end
    end
  end

  // Character count and sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || finish_now) begin
      len      <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (do_write) begin
        len <= len + LEN_ONE;
      end else if (do_erase) begin
        len <= len - LEN_ONE;
      end
      if (commit_letter && (len == LEN_FULL)) begin
        overflow <= 1'b1;
      end
    end
  end

  // One register per character slot; slot i is written when it is the next
  // free slot and cleared when it is the last filled slot being erased.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_slot
    localparam logic [3:0] IDX      = 4'(i);
    localparam logic [3:0] IDX_NEXT = 4'(i + 1);
    logic [CHAR_W-1:0] slot_q;

    // Slot storage: load on letter commit, clear on backspace/finish/reset.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n || finish_now) begin
        slot_q <= '0;
      end else if (do_write && (len == IDX)) begin
        slot_q <= CHAR_W'(i_code);
      end else if (do_erase && (len == IDX_NEXT)) begin
        slot_q <= '0;
      end
    end

    assign o_word[i*CHAR_W +: CHAR_W] = slot_q;
  end

  assign o_start    = (state == S_START);
  assign o_busy     = (state != S_COLLECT);
  assign o_len      = len;
  assign o_overflow = overflow;

endmodule
`default_nettype wire
